// File: rtl/reconf_fir_tdm_if.sv
// reconf_fir_tdm_if: sample, coefficient-port and result signals of the
// time-multiplexed FIR, grouped so the filter and its driver share one bundle.
//   master : sample strobe/data, coefficient RAM port, commit request,
//            tap count and overrun clear out; results and readback in
//   slave  : the filter side (mirror of master)
// Signal names follow the surrounding FIR datapath so existing hookups carry over.
interface reconf_fir_tdm_if #(
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned OUT_W   = 16
);
    logic                      iEnSample_300k;
    logic signed [DATA_W-1:0]  iFirIn;
    logic                      iCsnRam;
    logic                      iWrnRam;
    logic [ADDR_W-1:0]         iAddrRam;
    logic [COEFF_W-1:0]        iWrDtRam;
    logic [COEFF_W-1:0]        oRdDtRam;
    logic                      iCoeffiUpdateFlag;
    logic [ADDR_W-1:0]         iNumOfCoeff;
    logic                      iClrOverrun;
    logic signed [OUT_W-1:0]   oFirOut;
    logic                      oFirValid;
    logic                      oBusy;
    logic                      oOverrun;

    modport master (
        output iEnSample_300k, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
               iCoeffiUpdateFlag, iNumOfCoeff, iClrOverrun,
        input  oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample_300k, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
               iCoeffiUpdateFlag, iNumOfCoeff, iClrOverrun,
        output oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun
    );
endinterface

// File: rtl/reconf_fir_tdm.sv
// reconf_fir_tdm: transposed-form FIR with a single multiplier and adder,
// evaluating one tap per clock after each sample strobe. Coefficients are
// written to a shadow bank through an SRAM-style port and copied atomically
// into the active bank on commit, together with the runtime tap count.
// Ports:
//   iClk_12M : clock
//   iRsn     : asynchronous active-low reset
//   bus      : reconf_fir_tdm_if.slave (sample in, coefficient port,
//              commit/tap count, result, busy, overrun)
// Optional feature: define FIR_SAT_EN to saturate the output to OUT_W
// instead of wrapping by truncation.
module reconf_fir_tdm #(
    parameter int unsigned DATA_W    = 3,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned MAX_TAPS  = 33,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                iClk_12M,
    input  logic                iRsn,
    reconf_fir_tdm_if.slave     bus
);
    localparam int unsigned ACC_W = DATA_W + COEFF_W + $clog2(MAX_TAPS);
    localparam int unsigned IDX_W = $clog2(MAX_TAPS);
    localparam int unsigned CNT_W = $clog2(MAX_TAPS + 1);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_COMMIT
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           k_q, k_d;
    logic [CNT_W-1:0]           n_q, n_d;
    logic signed [DATA_W-1:0]   x_q, x_d;
    logic signed [ACC_W-1:0]    y_q, y_d;
    logic                       pend_q, pend_d;
    logic                       ovr_q, ovr_d;
    logic signed [OUT_W-1:0]    fir_out_q, fir_out_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic [COEFF_W-1:0]         rd_q;

    logic signed [COEFF_W-1:0]  shadow_q [MAX_TAPS];
    logic signed [COEFF_W-1:0]  active_q [MAX_TAPS];
    // Element 0 is never written: tap 0 lands in y instead.
    logic signed [ACC_W-1:0]    s_q      [MAX_TAPS];

    logic                       s_we_c;
    logic                       commit_c;
    logic                       drop_c;
    logic [CNT_W-1:0]           kp1_c;
    logic                       has_s_c;
    logic [IDX_W-1:0]           s_idx_c;
    logic signed [ACC_W-1:0]    s_in_c;
    logic signed [ACC_W-1:0]    coef_c;
    logic signed [ACC_W-1:0]    xext_c;
    logic signed [ACC_W-1:0]    tap_c;
    logic signed [ACC_W-1:0]    acc_fin_c;
    logic signed [ACC_W-1:0]    shifted_c;
    logic signed [OUT_W-1:0]    red_c;
    logic [CNT_W-1:0]           n_clamp_c;
    logic                       addr_ok_c;
    logic [IDX_W-1:0]           addr_idx_c;

    // Single tap: active[k]*x plus the older partial sum one stage up.
    always_comb begin
        kp1_c   = CNT_W'(k_q) + CNT_W'(1);
        has_s_c = (kp1_c < n_q);
        s_idx_c = has_s_c ? IDX_W'(kp1_c) : '0;
        s_in_c  = has_s_c ? s_q[s_idx_c] : '0;
        coef_c  = ACC_W'(active_q[k_q]);
        xext_c  = ACC_W'(x_q);
        tap_c   = coef_c * xext_c + s_in_c;
    end

    // With a single tap the result is still in flight, so bypass y_q.
    always_comb begin
        acc_fin_c = (k_q == '0) ? tap_c : y_q;
        shifted_c = acc_fin_c >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (shifted_c > SAT_HI) begin
            red_c = OUT_W'(SAT_HI);
        end else if (shifted_c < SAT_LO) begin
            red_c = OUT_W'(SAT_LO);
        end else begin
            red_c = OUT_W'(shifted_c);
        end
`else
        red_c = OUT_W'(shifted_c);
`endif
    end

    // Tap count clamp to 1..MAX_TAPS.
    always_comb begin
        if (bus.iNumOfCoeff == '0) begin
            n_clamp_c = CNT_W'(1);
        end else if (32'(bus.iNumOfCoeff) > MAX_TAPS) begin
            n_clamp_c = CNT_W'(MAX_TAPS);
        end else begin
            n_clamp_c = CNT_W'(bus.iNumOfCoeff);
        end
        addr_ok_c  = (32'(bus.iAddrRam) < MAX_TAPS);
        addr_idx_c = IDX_W'(bus.iAddrRam);
    end

    // Next-state and control.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        x_d       = x_q;
        y_d       = y_q;
        pend_d    = pend_q | bus.iCoeffiUpdateFlag;
        ovr_d     = bus.iClrOverrun ? 1'b0 : ovr_q;
        fir_out_d = fir_out_q;
        valid_d   = 1'b0;
        s_we_c    = 1'b0;
        commit_c  = 1'b0;
        drop_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Strobe wins over a pending commit; the commit waits.
                if (bus.iEnSample_300k) begin
                    x_d     = bus.iFirIn;
                    k_d     = '0;
                    state_d = S_COMPUTE;
                end else if (pend_q) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMPUTE: begin
                drop_c = bus.iEnSample_300k;
                if (k_q == '0) begin
                    y_d = tap_c;
                end else begin
                    s_we_c = 1'b1;
                end
                if (kp1_c == n_q) begin
                    fir_out_d = red_c;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                // A sample landing on the one-cycle commit has nowhere to go.
                drop_c   = bus.iEnSample_300k;
                commit_c = 1'b1;
                n_d      = n_clamp_c;
                pend_d   = bus.iCoeffiUpdateFlag;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop_c) begin
            ovr_d = 1'b1;
        end
        busy_d = (state_d == S_COMPUTE);
    end

    // State, datapath, coefficient banks and partial sums.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_q       <= CNT_W'(1);
            x_q       <= '0;
            y_q       <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            fir_out_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < int'(MAX_TAPS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                s_q[i]      <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            fir_out_q <= fir_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;

            if (!bus.iCsnRam && !bus.iWrnRam && addr_ok_c) begin
                shadow_q[addr_idx_c] <= bus.iWrDtRam;
            end
            if (!bus.iCsnRam && bus.iWrnRam) begin
                rd_q <= addr_ok_c ? shadow_q[addr_idx_c] : '0;
            end

            if (s_we_c) begin
                s_q[k_q] <= tap_c;
            end
            // Commit copies the pre-edge shadow, so a same-cycle write is not taken.
            if (commit_c) begin
                for (int i = 0; i < int'(MAX_TAPS); i++) begin
                    active_q[i] <= shadow_q[i];
                    s_q[i]      <= '0;
                end
            end
        end
    end

    assign bus.oRdDtRam  = rd_q;
    assign bus.oFirOut   = fir_out_q;
    assign bus.oFirValid = valid_q;
    assign bus.oBusy     = busy_q;
    assign bus.oOverrun  = ovr_q;

endmodule

// File: tb/tb_reconf_fir_tdm.sv
// tb_reconf_fir_tdm: directed stimulus with a scoreboard queue of expected
// outputs (value and arrival cycle) drained by an independent monitor.
module tb_reconf_fir_tdm;
    localparam int unsigned DATA_W    = 3;
    localparam int unsigned COEFF_W   = 16;
    localparam int unsigned MAX_TAPS  = 33;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned OUT_SHIFT = 0;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    typedef struct {
        int     val;
        longint cyc;
    } exp_t;
    exp_t sb_q[$];

    reconf_fir_tdm_if #(
        .DATA_W (DATA_W),
        .COEFF_W(COEFF_W),
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) bus ();

    reconf_fir_tdm #(
        .DATA_W   (DATA_W),
        .COEFF_W  (COEFF_W),
        .MAX_TAPS (MAX_TAPS),
        .ADDR_W   (ADDR_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .iClk_12M(clk),
        .iRsn    (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.oFirValid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("fir_out", longint'(bus.oFirOut), longint'(e.val));
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b0;
        bus.iAddrRam = ADDR_W'(a);
        bus.iWrDtRam = COEFF_W'(d);
        @(negedge clk);
        bus.iCsnRam  = 1'b1;
        bus.iWrnRam  = 1'b1;
    endtask

    task automatic rd(input int a, input int exp, input string name);
        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b1;
        bus.iAddrRam = ADDR_W'(a);
        @(negedge clk);
        bus.iCsnRam  = 1'b1;
        chk(name, longint'(bus.oRdDtRam), longint'(exp));
    endtask

    task automatic commit(input int n);
        bus.iNumOfCoeff       = ADDR_W'(n);
        bus.iCoeffiUpdateFlag = 1'b1;
        @(negedge clk);
        bus.iCoeffiUpdateFlag = 1'b0;
        tick(4);
    endtask

    // Strobe whose result is expected after n_taps clocks.
    task automatic sample(input int x, input int exp, input int n_taps);
        exp_t e;
        e.val = exp;
        e.cyc = cyc + 1 + longint'(n_taps);
        sb_q.push_back(e);
        bus.iFirIn         = DATA_W'(x);
        bus.iEnSample_300k = 1'b1;
        @(negedge clk);
        bus.iEnSample_300k = 1'b0;
    endtask

    // Strobe that must produce no result.
    task automatic strobe_only(input int x);
        bus.iFirIn         = DATA_W'(x);
        bus.iEnSample_300k = 1'b1;
        @(negedge clk);
        bus.iEnSample_300k = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic signed [15:0] t16;
    longint             full;
    int                 expv;

    initial begin
        rst_n                 = 1'b0;
        bus.iEnSample_300k    = 1'b0;
        bus.iFirIn            = '0;
        bus.iCsnRam           = 1'b1;
        bus.iWrnRam           = 1'b1;
        bus.iAddrRam          = '0;
        bus.iWrDtRam          = '0;
        bus.iCoeffiUpdateFlag = 1'b0;
        bus.iNumOfCoeff       = ADDR_W'(1);
        bus.iClrOverrun       = 1'b0;
        tick(3);
        chk("rst_fir_out", longint'(bus.oFirOut), 0);
        chk("rst_valid", longint'(bus.oFirValid), 0);
        chk("rst_busy", longint'(bus.oBusy), 0);
        chk("rst_overrun", longint'(bus.oOverrun), 0);
        chk("rst_rddata", longint'(bus.oRdDtRam), 0);
        rst_n = 1'b1;
        tick(2);

        // Impulse response.
        wr(0, 10); wr(1, -20); wr(2, 30); wr(3, 40);
        commit(4);
        sample(1, 10, 4);  tick(39);
        sample(0, -20, 4); tick(39);
        sample(0, 30, 4);  tick(39);
        sample(0, 40, 4);  tick(39);

        // Shadow isolation, then commit clears partial sums.
        wr(0, 100);
        sample(1, 10, 4);  tick(39);
        commit(4);
        sample(1, 100, 4); tick(39);

        // Overrun: second strobe 5 clocks later is dropped.
        commit(33);
        sample(1, 100, 33);
        chk("busy_in_compute", longint'(bus.oBusy), 1);
        tick(4);
        strobe_only(2);
        chk("overrun_set", longint'(bus.oOverrun), 1);
        tick(40);
        chk("busy_after", longint'(bus.oBusy), 0);
        chk("overrun_sticky", longint'(bus.oOverrun), 1);
        bus.iClrOverrun = 1'b1;
        @(negedge clk);
        bus.iClrOverrun = 1'b0;
        chk("overrun_cleared", longint'(bus.oOverrun), 0);

        // Saturation / wrap: 33 x 32767, x = 3 held.
        for (int i = 0; i < 33; i++) wr(i, 32767);
        commit(33);
        for (int n = 0; n < 33; n++) begin
            full = 64'sd98301 * longint'(n + 1);
`ifdef FIR_SAT_EN
            expv = (full > 32767) ? 32767 : int'(full);
`else
            t16  = 16'(full);
            expv = int'(t16);
`endif
            sample(3, expv, 33);
            tick(39);
        end

        // Tap count clamping.
        wr(0, 5);
        commit(0);
        sample(-4, -20, 1); tick(9);
        commit(63);
        sample(-4, -20, 33); tick(39);
        rd(0, 5, "rd_addr0");

        // Reset in the middle of a computation.
        strobe_only(1);
        tick(3);
        strobe_only(1);
        tick(3);
        chk("pre_rst_busy", longint'(bus.oBusy), 1);
        chk("pre_rst_overrun", longint'(bus.oOverrun), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_fir_out", longint'(bus.oFirOut), 0);
        chk("midrst_valid", longint'(bus.oFirValid), 0);
        chk("midrst_busy", longint'(bus.oBusy), 0);
        chk("midrst_overrun", longint'(bus.oOverrun), 0);
        chk("midrst_rddata", longint'(bus.oRdDtRam), 0);
        tick(3);
        rst_n = 1'b1;
        tick(40);

        // Readback and out-of-range address.
        wr(7, 'h1234);
        rd(7, 'h1234, "rd_addr7");
        wr(40, 'h5555);
        rd(40, 0, "rd_addr40");

        tick(5);
        chk("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reconf_fir_tdm.md
Name: reconf_fir_tdm

Overview:
Parametrised, time-multiplexed transposed-form FIR filter for the reconfigurable FIR datapath. It replaces the fixed 33-tap, 4-bank structure with one multiplier and one adder. Taps are processed one per clock after each sample strobe. Coefficients are written into a shadow bank through the SRAM-style port and committed atomically to the active bank. The active tap count is selectable at runtime.

Parameters:
DATA_W, 3, signed input sample width
COEFF_W, 16, signed coefficient width
MAX_TAPS, 33, coefficient bank depth (>=2)
ADDR_W, 6, coefficient address width, 2^ADDR_W >= MAX_TAPS
OUT_W, 16, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output

Ports:
iClk_12M  in  1  system clock
iRsn  in  1  asynchronous active-low reset
iEnSample_300k  in  1  one-cycle sample strobe
iFirIn  in  DATA_W  signed input sample, valid with the strobe
iCsnRam  in  1  coefficient port chip select, active low
iWrnRam  in  1  0 = write, 1 = read
iAddrRam  in  ADDR_W  coefficient index 0..MAX_TAPS-1
iWrDtRam  in  COEFF_W  coefficient write data
oRdDtRam  out  COEFF_W  shadow-bank read data, registered
iCoeffiUpdateFlag  in  1  request to commit the shadow bank to the active bank
iNumOfCoeff  in  ADDR_W  active tap count N, sampled at commit
iClrOverrun  in  1  clears oOverrun
oFirOut  out  OUT_W  filter output, held between updates
oFirValid  out  1  one-cycle pulse when oFirOut updates
oBusy  out  1  high while in COMPUTE
oOverrun  out  1  sticky flag: a sample was dropped

Behaviour:
- Reset values: all outputs 0. Both coefficient banks, partial sums s[1..MAX_TAPS-1], and the sample latch are 0. Active N = 1. FSM is in IDLE. Reset asserted mid-COMPUTE aborts immediately with no output pulse.
- Accumulator width: ACC_W = DATA_W + COEFF_W + clog2(MAX_TAPS). Products and sums are sign-extended to ACC_W.
- Coefficient port: a write (iCsnRam=0, iWrnRam=0) stores into shadow[addr] at the clock edge. A read (iCsnRam=0, iWrnRam=1) updates oRdDtRam on the next edge. An address >= MAX_TAPS is ignored on write and returns 0 on read. The port is usable in any state; it never touches the active bank.
- Tap count: N is clamped to the range 1..MAX_TAPS, so iNumOfCoeff=0 becomes 1 and values above MAX_TAPS become MAX_TAPS.
- FSM states IDLE, COMPUTE, COMMIT.
- IDLE, sample strobe: latch x = iFirIn, set k = 0, go to COMPUTE. Strobe takes priority over a pending commit.
- IDLE, commit pending and no strobe: go to COMMIT.
- COMPUTE, one tap per clock, k = 0..N-1:
  - t = active[k]*x + (k+1 < N ? s[k+1] : 0).
  - k = 0: y = t. k >= 1: s[k] = t.
  - Increasing k always reads the old s[k+1].
  - After k = N-1, return to IDLE. In the same edge, oFirOut = (y >>> OUT_SHIFT) reduced to OUT_W, and oFirValid pulses.
  - Latency from strobe edge to the oFirValid pulse is N clocks.
- COMPUTE, strobe arrives: sample dropped, oOverrun set. An edge with both a drop and iClrOverrun leaves oOverrun set.
- Commit request: iCoeffiUpdateFlag high on any edge sets a pending flag. In COMMIT (1 clock):
  - active bank <= shadow bank, N <= clamped iNumOfCoeff.
  - all s[] cleared to 0, pending cleared, return to IDLE.
  - A shadow write in the same cycle is written to shadow only; it is not committed.
- Output reduction without the feature: two's-complement truncation, keeping the low OUT_W bits.

Optional Feature:
FIR_SAT_EN. When defined, the shifted accumulator saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. When undefined, it wraps by truncation. The clamp is combinational before the oFirOut register and adds no latency.

Test Plan:
1. Impulse response: write shadow[0..3] = 10, -20, 30, 40; N = 4; commit. Drive samples x = 1 then 0,0,0 at 40-clk spacing. Outputs must be 10, -20, 30, 40, each oFirValid arriving 4 clk after its strobe.
2. Shadow isolation: after test 1, write shadow[0] = 100 without committing. Drive x = 1 and get output 10. Commit, drive x = 1, and get output 100; the partial sums were cleared, so there is no residue.
3. Overrun: N = 33, then two strobes 5 clk apart. The second strobe is dropped and oOverrun = 1; exactly one oFirValid pulse occurs. Pulse iClrOverrun and check oOverrun = 0.
4. Saturation: OUT_W = 16, all 33 coefficients = 32767, x = 3 held for 33 samples.
   - With FIR_SAT_EN: output 32767.
   - Without: output equals the low 16 bits of the exact sum.
5. Clamping and reset: iNumOfCoeff = 0 acts as 1 tap, so x = -4 with h0 = 5 gives -20 after 1 clk. iNumOfCoeff = 63 acts as 33 taps. Assert iRsn low mid-COMPUTE: all outputs become 0 and no oFirValid pulse occurs.
6. Readback: write addr 7 = 0x1234 and read it back as 0x1234 one clk later. Reading addr 40 returns 0.
